node_path_counter_wp: RTL and testbench
=======================================

Name: node_path_counter_wp

Overview:
- Generalised successor to the single-pair path counter: counts start-to-end paths in the decoded DAG that visit every one of NUM_WAYPOINTS mandatory waypoint nodes.
- Tracks 2^NUM_WAYPOINTS visited-mask states per node. NUM_WAYPOINTS=0 reduces to the plain path count.
- Sits between node_list_trim and tap_encoder. Consumes the indexed edge stream from node_id_mapper and the trimmed topological node stream.

Parameters:
- MAX_NODES, 1024, node index space; NODE_WIDTH=$clog2(MAX_NODES).
- MAX_EDGES, 4096, edge RAM depth; EDGE_WIDTH=$clog2(MAX_EDGES).
- NUM_WAYPOINTS, 2, mandatory waypoints, 0..4; MASKS=2**NUM_WAYPOINTS.
- RESULT_WIDTH, 16, count width; arithmetic wraps modulo 2^RESULT_WIDTH.

Ports:
- clk in 1 rising-edge clock (tck at top).
- rst in 1 synchronous active-high reset.
- decoding_done in 1 pulse: edge stream complete.
- edge_valid in 1 dst_node is an edge of the current source.
- src_node_valid in 1 src_node opens a new source group.
- src_node in NODE_WIDTH source index.
- dst_node in NODE_WIDTH destination index.
- start_node_idx in NODE_WIDTH start node.
- end_node_idx in NODE_WIDTH end node.
- start_end_nodes_valid in 1 level: start/end stable.
- waypoint_idx in max(1,NUM_WAYPOINTS*NODE_WIDTH) flattened waypoint indices; waypoint k at bits [k*NODE_WIDTH +: NODE_WIDTH].
- trimed_done in 1 pulse: sorted stream complete.
- trimed_valid in 1 sorted node strobe; no backpressure.
- trimed_node in NODE_WIDTH sorted node index.
- path_count_valid out 1 level: result ready.
- path_count_value out RESULT_WIDTH count of full-mask paths.
- path_count_overflow out 1 sticky: any count addition wrapped.
- edge_overflow out 1 sticky: edge RAM full, extra edges dropped.

Behaviour:
- Reset: all outputs 0, FIFO empty, write pointers 0, FSM to CLEAR. rst in any state aborts the run; the whole sequence restarts from CLEAR.
- Storage:
  - node RAM {base,count} per node; count=0 after clear.
  - edge RAM of dst indices.
  - count RAM of MAX_NODES*MASKS words; index = node*MASKS+mask.
  - sorted FIFO, depth MAX_NODES.
  - All RAMs have 1-cycle synchronous read.
- Load runs concurrently with CLEAR:
  - src_node_valid: latch current src; write node[src].base = edge write pointer.
  - edge_valid: write dst to edge RAM, increment edge pointer and node[src].count.
  - At MAX_EDGES, drop the edge and set edge_overflow.
  - A source reappearing overwrites its base; this is an unsupported input.
- Sorted capture: every trimed_valid pushes trimed_node, in any state after CLEAR starts. A push to a full FIFO is dropped.
- wpmask(n): bit k set iff n==waypoint k; computed combinationally.
- FSM:
  - CLEAR: write 0 to one count word per cycle, MAX_NODES*MASKS cycles.
  - WAIT_LOAD: until decoding_done has been seen (sticky) and start_end_nodes_valid=1.
  - SEED: cnt[start][wpmask(start)] = 1.
  - WAIT_SORT: until trimed_done has been seen (sticky).
  - POP: FIFO empty -> RESULT; else pop u, read node[u].
  - NODE: count=0 -> POP; else m=0.
  - RD_SRC: read cnt[u][m]; value 0 skips the mask (next m, or POP after last m); else e=0.
  - RD_EDGE: read edge[base+e] -> v.
  - RD_DST: read cnt[v][m|wpmask(v)].
  - WR_DST: write sum. Carry-out sets path_count_overflow. Next e; after the last e, next m; after the last m, POP.
  - RESULT: read cnt[end][MASKS-1].
  - DONE: drive path_count_value; path_count_valid=1 and held until rst.
- Each update is a strict read-then-write (2 cycles), so there is no RMW hazard. Per-edge-per-mask cost: 3 cycles.
- start==end: result is 1 iff start covers all waypoints. A waypoint set to start/end is counted as visited.
- Nodes absent from the sorted stream are never expanded.

Test Plan:
- W=0, edges you->a, you->b, a->out, b->out, start=you, end=out -> path_count_value=2, both overflow flags 0.
- W=2, waypoints dac,fft; edges svr->dac, svr->fft, dac->fft, dac->out, fft->out; start=svr, end=out -> value=1. Same graph with W=0 -> value=3.
- RESULT_WIDTH=4, W=0, chain of 5 diamonds (32 paths) -> value=0, path_count_overflow=1.
- MAX_EDGES=4, load 6 edges -> edge_overflow=1. Only the first 4 edges contribute to the count.
- Assert rst during the WR_DST phase of the first graph, then replay it -> path_count_valid goes low on the reset cycle; the replay yields value=2.
- Start node with zero out-edges, end≠start -> valid=1, value=0. Start==end, W=0 -> value=1.

Source files
------------

// File: rtl/node_path_counter_wp.sv
// Counts start-to-end paths in a DAG that visit every mandatory waypoint.
// Each node carries one path count per visited-waypoint mask; nodes are expanded in sorted order.
module node_path_counter_wp #(
  parameter int  MAX_NODES     = 1024,
  parameter int  MAX_EDGES     = 4096,
  parameter int  NUM_WAYPOINTS = 2,
  parameter int  RESULT_WIDTH  = 16,
  localparam int NODE_WIDTH    = $clog2(MAX_NODES),
  localparam int WP_W          = (NUM_WAYPOINTS == 0) ? 1 : NUM_WAYPOINTS * NODE_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    decoding_done,
  input  logic                    edge_valid,
  input  logic                    src_node_valid,
  input  logic [NODE_WIDTH-1:0]   src_node,
  input  logic [NODE_WIDTH-1:0]   dst_node,
  input  logic [NODE_WIDTH-1:0]   start_node_idx,
  input  logic [NODE_WIDTH-1:0]   end_node_idx,
  input  logic                    start_end_nodes_valid,
  input  logic [WP_W-1:0]         waypoint_idx,
  input  logic                    trimed_done,
  input  logic                    trimed_valid,
  input  logic [NODE_WIDTH-1:0]   trimed_node,
  output logic                    path_count_valid,
  output logic [RESULT_WIDTH-1:0] path_count_value,
  output logic                    path_count_overflow,
  output logic                    edge_overflow
);
  localparam int EDGE_WIDTH = $clog2(MAX_EDGES);
  localparam int EP_W       = EDGE_WIDTH + 1;
  localparam int MASKS      = 1 << NUM_WAYPOINTS;
  localparam int MW         = (NUM_WAYPOINTS == 0) ? 1 : NUM_WAYPOINTS;
  localparam int CNT_W      = $clog2(MAX_NODES * MASKS);
  localparam int WPP        = MW * NODE_WIDTH;

  typedef enum logic [3:0] {
    S_CLEAR, S_WAIT_LOAD, S_SEED, S_WAIT_SORT, S_POP, S_NODE,
    S_RD_SRC, S_RD_EDGE, S_RD_DST, S_WR_DST, S_RESULT, S_DONE
  } state_e;

  function automatic logic [CNT_W-1:0] cidx(input logic [NODE_WIDTH-1:0] n, input logic [MW-1:0] m);
    return CNT_W'(32'(n) * 32'(MASKS) + 32'(m));
  endfunction

  function automatic logic [MW-1:0] wpmask(input logic [NODE_WIDTH-1:0] n, input logic [WPP-1:0] wp);
    logic [MW-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_WAYPOINTS; k++)
      if (wp[k*NODE_WIDTH +: NODE_WIDTH] == n) r[k] = 1'b1;
    return r;
  endfunction

  // storage
  logic [EDGE_WIDTH-1:0]   nbase_mem [MAX_NODES];
  logic [EP_W-1:0]         ncnt_mem  [MAX_NODES];
  logic [NODE_WIDTH-1:0]   edge_mem  [MAX_EDGES];
  logic [RESULT_WIDTH-1:0] cnt_mem   [MAX_NODES*MASKS];
  logic [NODE_WIDTH-1:0]   fifo_mem  [MAX_NODES];

  // load side
  logic [EP_W-1:0]       eptr_q, scnt_q, cur_cnt, ncnt_wd;
  logic [NODE_WIDTH-1:0] src_q, cur_src;
  logic [EDGE_WIDTH-1:0] sbase_q, cur_base;
  logic [MAX_NODES-1:0]  seen_q;
  logic                  eovf_q, edge_full, edge_take, node_we;

  // sorted FIFO
  logic [NODE_WIDTH-1:0] fwr_q, frd_q, head;
  logic [NODE_WIDTH:0]   fcnt_q;
  logic                  push, pop;

  // expansion FSM
  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        clr_q, clr_d, didx_q, v_idx, cnt_wa, cnt_ra;
  logic [NODE_WIDTH-1:0]   u_q, edge_rd_q;
  logic [MW-1:0]           m_q, m_d, wp_start, wp_v;
  logic                    m_last;
  logic [EP_W-1:0]         e_q, e_d, nc_q;
  logic [EDGE_WIDTH-1:0]   nb_q, eaddr;
  logic [RESULT_WIDTH-1:0] srcv_q, cnt_rd_q, cnt_wd, res_q;
  logic [RESULT_WIDTH:0]   sum_w;
  logic                    cnt_we, node_re, dec_seen_q, sort_seen_q, valid_q, povf_q;
  logic [WPP-1:0]          wp_pad;

  // An edge may arrive in the same cycle that opens its source group.
  assign cur_src   = src_node_valid ? src_node : src_q;
  assign cur_base  = src_node_valid ? eptr_q[EDGE_WIDTH-1:0] : sbase_q;
  assign cur_cnt   = src_node_valid ? '0 : scnt_q;
  assign edge_full = (eptr_q == EP_W'(MAX_EDGES));
  assign edge_take = edge_valid && !edge_full;
  assign node_we   = src_node_valid || edge_take;
  assign ncnt_wd   = cur_cnt + (edge_take ? EP_W'(1) : EP_W'(0));

  always_ff @(posedge clk) begin
    if (rst) begin
      eptr_q  <= '0;
      scnt_q  <= '0;
      src_q   <= '0;
      sbase_q <= '0;
      seen_q  <= '0;
      eovf_q  <= 1'b0;
    end else begin
      if (src_node_valid) begin
        src_q   <= src_node;
        sbase_q <= eptr_q[EDGE_WIDTH-1:0];
        scnt_q  <= '0;
      end
      if (edge_take) begin
        eptr_q <= eptr_q + EP_W'(1);
        scnt_q <= ncnt_wd;
      end
      if (edge_valid && edge_full) eovf_q <= 1'b1;
      if (node_we) seen_q[cur_src] <= 1'b1;
    end
  end

  assign head     = fifo_mem[frd_q];
  assign push     = trimed_valid && (fcnt_q != (NODE_WIDTH+1)'(MAX_NODES));
  assign pop      = node_re;
  assign wp_pad   = WPP'(waypoint_idx);
  assign wp_start = wpmask(start_node_idx, wp_pad);
  assign wp_v     = wpmask(edge_rd_q, wp_pad);
  assign v_idx    = cidx(edge_rd_q, m_q | wp_v);
  assign eaddr    = nb_q + e_q[EDGE_WIDTH-1:0];
  assign m_last   = (m_q == MW'(MASKS - 1));
  assign sum_w    = {1'b0, cnt_rd_q} + {1'b0, srcv_q};

  // The next mask's source word is read one state ahead so RD_SRC sees it immediately.
  always_comb begin
    if (state_q == S_RD_DST)                          cnt_ra = v_idx;
    else if (state_q == S_RESULT || state_q == S_DONE) cnt_ra = cidx(end_node_idx, MW'(MASKS - 1));
    else                                              cnt_ra = cidx(u_q, m_d);
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    e_d     = e_q;
    clr_d   = clr_q;
    cnt_we  = 1'b0;
    cnt_wa  = clr_q;
    cnt_wd  = '0;
    node_re = 1'b0;
    case (state_q)
      S_CLEAR: begin
        cnt_we = 1'b1;
        clr_d  = clr_q + CNT_W'(1);
        if (clr_q == CNT_W'(MAX_NODES * MASKS - 1)) state_d = S_WAIT_LOAD;
      end
      S_WAIT_LOAD: if ((dec_seen_q || decoding_done) && start_end_nodes_valid) state_d = S_SEED;
      S_SEED: begin
        cnt_we  = 1'b1;
        cnt_wa  = cidx(start_node_idx, wp_start);
        cnt_wd  = RESULT_WIDTH'(1);
        state_d = S_WAIT_SORT;
      end
      S_WAIT_SORT: if (sort_seen_q || trimed_done) state_d = S_POP;
      S_POP: begin
        if (fcnt_q == '0) state_d = S_RESULT;
        else begin
          node_re = 1'b1;
          state_d = S_NODE;
        end
      end
      S_NODE: begin
        if (nc_q == '0) state_d = S_POP;
        else begin
          m_d     = '0;
          state_d = S_RD_SRC;
        end
      end
      S_RD_SRC: begin
        if (cnt_rd_q == '0) begin
          if (m_last) state_d = S_POP;
          else        m_d = m_q + MW'(1);
        end else begin
          e_d     = '0;
          state_d = S_RD_EDGE;
        end
      end
      S_RD_EDGE: state_d = S_RD_DST;
      S_RD_DST:  state_d = S_WR_DST;
      S_WR_DST: begin
        cnt_we = 1'b1;
        cnt_wa = didx_q;
        cnt_wd = sum_w[RESULT_WIDTH-1:0];
        if (e_q + EP_W'(1) == nc_q) begin
          if (m_last) state_d = S_POP;
          else begin
            m_d     = m_q + MW'(1);
            state_d = S_RD_SRC;
          end
        end else begin
          e_d     = e_q + EP_W'(1);
          state_d = S_RD_EDGE;
        end
      end
      S_RESULT: state_d = S_DONE;
      S_DONE:   state_d = S_DONE;
      default:  state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_CLEAR;
      clr_q       <= '0;
      u_q         <= '0;
      m_q         <= '0;
      e_q         <= '0;
      srcv_q      <= '0;
      didx_q      <= '0;
      dec_seen_q  <= 1'b0;
      sort_seen_q <= 1'b0;
      valid_q     <= 1'b0;
      res_q       <= '0;
      povf_q      <= 1'b0;
      fwr_q       <= '0;
      frd_q       <= '0;
      fcnt_q      <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      m_q     <= m_d;
      e_q     <= e_d;
      if (decoding_done) dec_seen_q  <= 1'b1;
      if (trimed_done)   sort_seen_q <= 1'b1;
      if (node_re) u_q <= head;
      if (state_q == S_RD_SRC) srcv_q <= cnt_rd_q;
      if (state_q == S_RD_DST) didx_q <= v_idx;
      if (state_q == S_WR_DST && sum_w[RESULT_WIDTH]) povf_q <= 1'b1;
      if (state_q == S_DONE) begin
        valid_q <= 1'b1;
        res_q   <= cnt_rd_q;
      end
      if (push) fwr_q <= (fwr_q == NODE_WIDTH'(MAX_NODES - 1)) ? '0 : fwr_q + NODE_WIDTH'(1);
      if (pop)  frd_q <= (frd_q == NODE_WIDTH'(MAX_NODES - 1)) ? '0 : frd_q + NODE_WIDTH'(1);
      case ({push, pop})
        2'b10:   fcnt_q <= fcnt_q + (NODE_WIDTH+1)'(1);
        2'b01:   fcnt_q <= fcnt_q - (NODE_WIDTH+1)'(1);
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end

  // RAM ports: one write and one registered read each.
  always_ff @(posedge clk) begin
    if (node_we) begin
      nbase_mem[cur_src] <= cur_base;
      ncnt_mem[cur_src]  <= ncnt_wd;
    end
    if (edge_take) edge_mem[eptr_q[EDGE_WIDTH-1:0]] <= dst_node;
    if (cnt_we)    cnt_mem[cnt_wa] <= cnt_wd;
    if (push)      fifo_mem[fwr_q] <= trimed_node;
    if (node_re) begin
      nb_q <= nbase_mem[head];
      nc_q <= seen_q[head] ? ncnt_mem[head] : '0;
    end
    edge_rd_q <= edge_mem[eaddr];
    cnt_rd_q  <= cnt_mem[cnt_ra];
  end

  assign path_count_valid    = valid_q;
  assign path_count_value    = res_q;
  assign path_count_overflow = povf_q;
  assign edge_overflow       = eovf_q;
endmodule

// File: tb/tb_node_path_counter_wp.sv
// Directed bench: four parameterisations share one stimulus stream, each checked against hand-computed counts.
module tb_node_path_counter_wp;
  localparam int NW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, decoding_done, edge_valid, src_node_valid, start_end_nodes_valid;
  logic          trimed_done, trimed_valid;
  logic [NW-1:0] src_node, dst_node, start_node_idx, end_node_idx, trimed_node;
  logic [2*NW-1:0] wp2;
  logic          wp0;
  logic [3:0]    vld, povf, eovf;
  logic [15:0]   val_w0, val_w2, val_me4;
  logic [3:0]    val_rw4;

  int checks = 0, errors = 0;
  int es[$], ed[$], ord[$];

  node_path_counter_wp #(.MAX_NODES(16), .MAX_EDGES(32), .NUM_WAYPOINTS(0), .RESULT_WIDTH(16)) u_w0 (
    .clk(clk), .rst(rst), .decoding_done(decoding_done), .edge_valid(edge_valid),
    .src_node_valid(src_node_valid), .src_node(src_node), .dst_node(dst_node),
    .start_node_idx(start_node_idx), .end_node_idx(end_node_idx),
    .start_end_nodes_valid(start_end_nodes_valid), .waypoint_idx(wp0), .trimed_done(trimed_done),
    .trimed_valid(trimed_valid), .trimed_node(trimed_node), .path_count_valid(vld[0]),
    .path_count_value(val_w0), .path_count_overflow(povf[0]), .edge_overflow(eovf[0]));

  node_path_counter_wp #(.MAX_NODES(16), .MAX_EDGES(32), .NUM_WAYPOINTS(2), .RESULT_WIDTH(16)) u_w2 (
    .clk(clk), .rst(rst), .decoding_done(decoding_done), .edge_valid(edge_valid),
    .src_node_valid(src_node_valid), .src_node(src_node), .dst_node(dst_node),
    .start_node_idx(start_node_idx), .end_node_idx(end_node_idx),
    .start_end_nodes_valid(start_end_nodes_valid), .waypoint_idx(wp2), .trimed_done(trimed_done),
    .trimed_valid(trimed_valid), .trimed_node(trimed_node), .path_count_valid(vld[1]),
    .path_count_value(val_w2), .path_count_overflow(povf[1]), .edge_overflow(eovf[1]));

  node_path_counter_wp #(.MAX_NODES(16), .MAX_EDGES(32), .NUM_WAYPOINTS(0), .RESULT_WIDTH(4)) u_rw4 (
    .clk(clk), .rst(rst), .decoding_done(decoding_done), .edge_valid(edge_valid),
    .src_node_valid(src_node_valid), .src_node(src_node), .dst_node(dst_node),
    .start_node_idx(start_node_idx), .end_node_idx(end_node_idx),
    .start_end_nodes_valid(start_end_nodes_valid), .waypoint_idx(wp0), .trimed_done(trimed_done),
    .trimed_valid(trimed_valid), .trimed_node(trimed_node), .path_count_valid(vld[2]),
    .path_count_value(val_rw4), .path_count_overflow(povf[2]), .edge_overflow(eovf[2]));

  node_path_counter_wp #(.MAX_NODES(16), .MAX_EDGES(4), .NUM_WAYPOINTS(0), .RESULT_WIDTH(16)) u_me4 (
    .clk(clk), .rst(rst), .decoding_done(decoding_done), .edge_valid(edge_valid),
    .src_node_valid(src_node_valid), .src_node(src_node), .dst_node(dst_node),
    .start_node_idx(start_node_idx), .end_node_idx(end_node_idx),
    .start_end_nodes_valid(start_end_nodes_valid), .waypoint_idx(wp0), .trimed_done(trimed_done),
    .trimed_valid(trimed_valid), .trimed_node(trimed_node), .path_count_valid(vld[3]),
    .path_count_value(val_me4), .path_count_overflow(povf[3]), .edge_overflow(eovf[3]));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic load_graph(input int s, input int e, input int wa, input int wb);
    rst = 1'b1;
    decoding_done = 1'b0; edge_valid = 1'b0; src_node_valid = 1'b0;
    trimed_valid = 1'b0; trimed_done = 1'b0;
    start_node_idx = NW'(s); end_node_idx = NW'(e); start_end_nodes_valid = 1'b1;
    wp2 = {NW'(wb), NW'(wa)};
    tick; tick;
    rst = 1'b0;
    for (int i = 0; i < es.size(); i++) begin
      if (i == 0 || es[i] != es[i-1]) begin
        src_node_valid = 1'b1; src_node = NW'(es[i]); tick; src_node_valid = 1'b0;
      end
      edge_valid = 1'b1; dst_node = NW'(ed[i]); tick; edge_valid = 1'b0;
    end
    decoding_done = 1'b1; tick; decoding_done = 1'b0;
    for (int i = 0; i < ord.size(); i++) begin
      trimed_valid = 1'b1; trimed_node = NW'(ord[i]); tick; trimed_valid = 1'b0;
    end
    trimed_done = 1'b1; tick; trimed_done = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (vld != 4'hF && n < 3000) begin
      tick;
      n++;
    end
    chk(tag, int'(vld), 15);
  endtask

  initial begin
    rst = 1'b1; decoding_done = 1'b0; edge_valid = 1'b0; src_node_valid = 1'b0;
    trimed_valid = 1'b0; trimed_done = 1'b0; start_end_nodes_valid = 1'b0;
    src_node = '0; dst_node = '0; start_node_idx = '0; end_node_idx = '0; trimed_node = '0;
    wp2 = '0; wp0 = 1'b0;
    tick; tick;
    chk("rst_valid", int'(vld), 0);
    chk("rst_value", int'(val_w0), 0);
    chk("rst_povf", int'(povf), 0);
    chk("rst_eovf", int'(eovf), 0);

    // two-branch graph; waypoints on start and end count as visited
    es = '{0, 0, 1, 2}; ed = '{1, 2, 3, 3}; ord = '{0, 1, 2, 3};
    load_graph(0, 3, 0, 3);
    wait_done("t1_done");
    chk("t1_w0", int'(val_w0), 2);
    chk("t1_w2", int'(val_w2), 2);
    chk("t1_rw4", int'(val_rw4), 2);
    chk("t1_povf", int'(povf), 0);
    chk("t1_eovf", int'(eovf[0]), 0);
    rst = 1'b1; tick;
    chk("t1_rst_valid", int'(vld), 0);
    chk("t1_rst_value", int'(val_w0), 0);

    // svr/dac/fft/out: waypoint filtering
    es = '{0, 0, 1, 1, 2}; ed = '{1, 2, 2, 3, 3}; ord = '{0, 1, 2, 3};
    load_graph(0, 3, 1, 2);
    wait_done("t2_done");
    chk("t2_w2", int'(val_w2), 1);
    chk("t2_w0", int'(val_w0), 3);

    // five chained diamonds: 32 paths wrap a 4-bit count
    es.delete(); ed.delete(); ord.delete();
    for (int i = 0; i < 5; i++) begin
      es.push_back(3*i);   ed.push_back(3*i+1);
      es.push_back(3*i);   ed.push_back(3*i+2);
      es.push_back(3*i+1); ed.push_back(3*i+3);
      es.push_back(3*i+2); ed.push_back(3*i+3);
    end
    for (int i = 0; i < 16; i++) ord.push_back(i);
    load_graph(0, 15, 3, 9);
    wait_done("t3_done");
    chk("t3_rw4", int'(val_rw4), 0);
    chk("t3_rw4_povf", int'(povf[2]), 1);
    chk("t3_w0", int'(val_w0), 32);
    chk("t3_w0_povf", int'(povf[0]), 0);
    chk("t3_w2", int'(val_w2), 32);
    chk("t3_me4", int'(val_me4), 0);
    chk("t3_me4_eovf", int'(eovf[3]), 1);

    // six edges into a 4-entry edge RAM
    es = '{0, 0, 0, 1, 2, 2}; ed = '{1, 2, 3, 3, 3, 1}; ord = '{0, 2, 1, 3};
    load_graph(0, 3, 1, 3);
    wait_done("t4_done");
    chk("t4_me4", int'(val_me4), 2);
    chk("t4_me4_eovf", int'(eovf[3]), 1);
    chk("t4_w0", int'(val_w0), 4);
    chk("t4_w0_eovf", int'(eovf[0]), 0);
    chk("t4_w2", int'(val_w2), 2);

    // abort mid-expansion, then replay the first graph
    es = '{0, 0, 1, 2}; ed = '{1, 2, 3, 3}; ord = '{0, 1, 2, 3};
    load_graph(0, 3, 0, 3);
    begin
      int n = 0;
      while (int'(u_w0.state_q) != 9 && n < 500) begin
        tick;
        n++;
      end
      chk("t5_reach_wr", int'(n < 500), 1);
    end
    rst = 1'b1; tick;
    chk("t5_rst_valid", int'(vld[0]), 0);
    load_graph(0, 3, 0, 3);
    wait_done("t5_done");
    chk("t5_w0", int'(val_w0), 2);

    // start with no out-edges
    load_graph(3, 0, 1, 2);
    wait_done("t6a_done");
    chk("t6a_w0", int'(val_w0), 0);
    chk("t6a_w2", int'(val_w2), 0);

    // start == end
    load_graph(1, 1, 1, 1);
    wait_done("t6b_done");
    chk("t6b_w0", int'(val_w0), 1);
    chk("t6b_w2", int'(val_w2), 1);
    load_graph(1, 1, 1, 2);
    wait_done("t6c_done");
    chk("t6c_w2", int'(val_w2), 0);
    chk("t6c_w0", int'(val_w0), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
